// File: rtl/spi_tx_scheduler.sv
// Round-robin arbiter that hands one requester word at a time to a shared SPI master,
// tracks the frame through chip-select and enforces a guard gap before the next grant.
module spi_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int DW         = 12,
    parameter int TIMEOUT    = 2048,
    parameter int GAP_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      spi_newd,
    output logic [DW-1:0]             spi_din,
    input  logic                      spi_cs,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      err
);

    localparam int IDW     = $clog2(NREQ);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [IDW-1:0]    last_grant_r, last_nxt_s;
    logic              spi_newd_r, newd_nxt_s;
    logic [DW-1:0]     spi_din_r, din_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic [IDW-1:0]    done_id_r, id_nxt_s;
    logic              err_r, err_nxt_s;
    logic [IDW:0]      pick_s;
    logic              grant_vld_s;
    logic [IDW-1:0]    grant_s;
    logic [NREQ-1:0]   ready_s;

    // Result MSB flags a hit; the lowest offset after the last grant wins, so scan downward.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0] last);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (valid[idx]) begin
                res = {1'b1, idx[IDW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, grant and output-register computation.
    always_comb begin
        pick_s      = rr_pick(req_valid, last_grant_r);
        grant_vld_s = pick_s[IDW];
        grant_s     = pick_s[IDW-1:0];
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_grant_r;
        newd_nxt_s  = 1'b0;
        din_nxt_s   = spi_din_r;
        id_nxt_s    = done_id_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        ready_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    ready_s[grant_s] = 1'b1;
                    din_nxt_s        = req_data[grant_s*DW +: DW];
                    id_nxt_s         = grant_s;
                    last_nxt_s       = grant_s;
                    newd_nxt_s       = 1'b1;
                    cnt_nxt_s        = '0;
                    state_nxt_s      = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A falling cs takes precedence over a timeout landing on the same cycle.
                if (!spi_cs) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_WAIT_DONE;
                end else if (cnt_r == TO_LAST) begin
                    err_nxt_s   = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    newd_nxt_s = 1'b1;
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (spi_cs) begin
                    done_nxt_s  = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_grant_r <= IDW'(NREQ - 1);
            spi_newd_r   <= 1'b0;
            spi_din_r    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            done_id_r    <= '0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            last_grant_r <= last_nxt_s;
            spi_newd_r   <= newd_nxt_s;
            spi_din_r    <= din_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            done_id_r    <= id_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    assign req_ready = ready_s;
    assign spi_newd  = spi_newd_r;
    assign spi_din   = spi_din_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign done_id   = done_id_r;
    assign err       = err_r;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler: event-timestamp reference model checked every cycle,
// plus literal expectations for grant order, newd hold time, gap length and timeout.
module tb_spi_tx_scheduler;

    localparam int NREQ       = 4;
    localparam int DW         = 12;
    localparam int TIMEOUT    = 2048;
    localparam int GAP_CYCLES = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 spi_newd;
    logic [DW-1:0]        spi_din;
    logic                 spi_cs;
    logic                 busy, done, err;
    logic [1:0]           done_id;

    spi_tx_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs),
        .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic int rr_next(input logic [NREQ-1:0] v, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (v[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: frame progress tracked as edge timestamps of grant, cs fall and cs rise.
    bit            chk_en = 1'b0;
    int            n_edge = 0;
    bit            m_idle, m_newd, m_fell, m_rose, m_done, m_err;
    int            m_grant_edge, m_rise_edge, m_id, m_last, m_g;
    logic [DW-1:0] m_din;

    always @(posedge clk) begin
        n_edge++;
        if (rst) begin
            chk_en = 1'b1; m_idle = 1'b1; m_newd = 1'b0; m_din = '0; m_id = 0;
            m_done = 1'b0; m_err = 1'b0; m_last = NREQ - 1;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_idle) begin
                if (req_valid != '0) begin
                    m_g = rr_next(req_valid, m_last);
                    m_last = m_g; m_id = m_g; m_din = req_data[m_g*DW +: DW];
                    m_newd = 1'b1; m_idle = 1'b0; m_fell = 1'b0; m_rose = 1'b0;
                    m_grant_edge = n_edge;
                end
            end else if (!m_fell) begin
                if (!spi_cs) begin
                    m_fell = 1'b1; m_newd = 1'b0;
                end else if (n_edge - m_grant_edge == TIMEOUT) begin
                    m_newd = 1'b0; m_err = 1'b1; m_idle = 1'b1;
                end
            end else if (!m_rose) begin
                if (spi_cs) begin
                    m_rose = 1'b1; m_done = 1'b1; m_rise_edge = n_edge;
                    m_idle = (GAP_CYCLES == 0);
                end
            end else if (n_edge - m_rise_edge == GAP_CYCLES) begin
                m_idle = 1'b1;
            end
        end
    end

    // Per-cycle comparison plus observation counters used by the directed checks.
    int              grants[$];
    int              newd_hi = 0, done_cnt = 0, err_cnt = 0;
    logic [NREQ-1:0] exp_ready;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ready = '0;
            if (m_idle && req_valid != '0) exp_ready[rr_next(req_valid, m_last)] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("spi_newd", 32'(spi_newd), 32'(m_newd));
            chk("spi_din", 32'(spi_din), 32'(m_din));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("done", 32'(done), 32'(m_done));
            chk("done_id", 32'(done_id), 32'(m_id));
            chk("err", 32'(err), 32'(m_err));
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1) begin
                    grants.push_back(i);
                    newd_hi = 0;
                end
            end
            if (spi_newd === 1'b1) newd_hi++;
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
        end
    end

    // SPI master stand-in: drops cs after fall_after cycles of newd, holds it low low_len cycles.
    int fall_after = 3, low_len = 5, nh = 0;
    bit cs_stuck = 1'b0;
    initial begin
        spi_cs = 1'b1;
        forever begin
            @(negedge clk);
            if (!cs_stuck && spi_newd === 1'b1) begin
                nh++;
                if (nh == fall_after) begin
                    spi_cs = 1'b0;
                    nh = 0;
                    repeat (low_len) @(negedge clk);
                    spi_cs = 1'b1;
                end
            end else begin
                nh = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int id);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (req_ready[id] !== 1'b1 && k < 3000);
        if (req_ready[id] !== 1'b1) bound_fail($sformatf("wait_ready%0d", id));
    endtask

    task automatic send(input int id, input logic [DW-1:0] d);
        tick();
        req_data[id*DW +: DW] = d;
        req_valid[id] = 1'b1;
        wait_ready(id);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (busy !== 1'b0 && k < 5000);
        if (busy !== 1'b0) bound_fail("wait_idle");
    endtask

    task automatic wait_sig(input string nm, input int which);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end
        while (((which == 0) ? done : err) !== 1'b1 && k < 3000);
        if (((which == 0) ? done : err) !== 1'b1) bound_fail(nm);
    endtask

    int e0, d0, k;

    initial begin
        // Reset values, then first grant goes to requester 0.
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_newd", 32'(spi_newd), 32'd0);
        chk("t1_ready", 32'(req_ready), 32'd0);
        chk("t1_din", 32'(spi_din), 32'd0);
        tick();
        req_data[0 +: DW] = 12'h0F0;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready_0001", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        wait_idle();

        tick(); rst = 1'b1; tick(); rst = 1'b0;

        // Round robin with every requester holding valid.
        fall_after = 2; low_len = 3;
        grants.delete();
        tick();
        req_data = {12'h404, 12'h303, 12'h202, 12'h101};
        req_valid = 4'b1111;
        k = 0;
        do begin @(negedge clk); k++; end while (grants.size() < 5 && k < 2000);
        if (grants.size() < 5) bound_fail("t3_five_grants");
        tick();
        req_valid = 4'b0000;
        wait_idle();
        chk("t3_count", 32'(grants.size()), 32'd5);
        if (grants.size() >= 5) begin
            chk("t3_g0", 32'(grants[0]), 32'd0);
            chk("t3_g1", 32'(grants[1]), 32'd1);
            chk("t3_g2", 32'(grants[2]), 32'd2);
            chk("t3_g3", 32'(grants[3]), 32'd3);
            chk("t3_g4", 32'(grants[4]), 32'd0);
        end

        // Single frame: newd held 30 cycles, one done, 32-cycle guard gap.
        fall_after = 30; low_len = 300;
        d0 = done_cnt;
        send(1, 12'hA5C);
        wait_sig("t2_done", 0);
        e0 = n_edge;
        chk("t2_newd_cycles", 32'(newd_hi), 32'd30);
        chk("t2_done_id", 32'(done_id), 32'd1);
        chk("t2_din", 32'(spi_din), 32'hA5C);
        tick();
        req_data[2*DW +: DW] = 12'h3C3;
        req_valid[2] = 1'b1;
        wait_ready(2);
        chk("t2_gap", 32'(n_edge - e0), 32'd32);
        chk("t2_ready_0100", 32'(req_ready), 32'h4);
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
        tick();
        req_valid[2] = 1'b0;
        fall_after = 3; low_len = 5;
        wait_idle();

        // Timeout with cs stuck high.
        cs_stuck = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        send(3, 12'h7E1);
        wait_sig("t4_err", 1);
        chk("t4_newd_cycles", 32'(newd_hi), 32'd2048);
        chk("t4_newd_low", 32'(spi_newd), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_err_once", 32'(err_cnt - e0), 32'd1);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        cs_stuck = 1'b0;

        // Reset while waiting for cs to rise.
        fall_after = 2; low_len = 60;
        send(2, 12'h555);
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(busy === 1'b1 && spi_newd === 1'b0 && spi_cs === 1'b0) && k < 100);
        if (spi_cs !== 1'b0) bound_fail("t5_wait_done");
        d0 = done_cnt;
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done_id", 32'(done_id), 32'd0);
        tick();
        req_valid = 4'b0101;
        k = 0;
        do begin @(negedge clk); k++; end while (req_ready === 4'b0000 && k < 100);
        chk("t5_ready_0001", 32'(req_ready), 32'h1);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        tick();
        req_valid = 4'b0000;
        wait_idle();

        // Sparse requests: pointer wraps from 2 back to 0.
        fall_after = 3; low_len = 5;
        grants.delete();
        send(2, 12'h222);
        send(0, 12'h999);
        wait_idle();
        chk("t6_count", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            chk("t6_g0", 32'(grants[0]), 32'd2);
            chk("t6_g1", 32'(grants[1]), 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1);
    end

endmodule
